branch_predictor_btb: RTL and testbench

- Parametrised branch target buffer with 2-bit saturating direction counters for the 5-stage RISC-V pipeline.
- Predicts direction and target at Fetch.
- Carries the prediction through Decode and Execute internally.
- Compares it with the Execute-stage resolution, then raises a mispredict redirect and trains the table.
- Successor to the fixed always-not-taken branch decision in the controller.

---
 rtl/bp_pkg.sv | 36 +++
 rtl/bp_pipe_reg.sv | 58 +++++
 rtl/branch_predictor_btb.sv | 202 ++++++++++++++++++++
 tb/tb_branch_predictor_btb.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor BTB.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// ctr_t is the 2-bit saturating direction counter. sat_update moves it
// one step toward the resolved direction and holds at SNT/ST.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  // Counters come out of reset weakly not-taken so a single taken
  // resolution is enough to flip the prediction.
  localparam ctr_t CTR_RST = WNT;

  function automatic ctr_t sat_update(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    case (c)
      SNT:     r = taken ? WNT : SNT;
      WNT:     r = taken ? WT  : SNT;
      WT:      r = taken ? ST  : WNT;
      default: r = taken ? ST  : WT;
    endcase
    return r;
  endfunction

  function automatic logic ctr_taken(input ctr_t c);
    return (c == WT) || (c == ST);
  endfunction

endpackage

// File: rtl/bp_pipe_reg.sv
// Prediction pipeline register carrying {taken, target, index} one stage.
// Latency: 1 cycle.
// Backpressure: stall holds contents; flush clears to 0 and wins over stall.
//
// Ports: clk, reset (sync, active-low), stall, flush,
//        taken_i/target_i/idx_i in, taken_o/target_o/idx_o out.
module bp_pipe_reg #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned IW   = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            taken_i,
  input  logic [XLEN-1:0] target_i,
  input  logic [IW-1:0]   idx_i,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o,
  output logic [IW-1:0]   idx_o
);

  logic            taken_q,  taken_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [IW-1:0]   idx_q,    idx_d;

  always_comb begin
    taken_d  = taken_q;
    target_d = target_q;
    idx_d    = idx_q;
    if (flush) begin
      taken_d  = 1'b0;
      target_d = '0;
      idx_d    = '0;
    end else if (!stall) begin
      taken_d  = taken_i;
      target_d = target_i;
      idx_d    = idx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      taken_q  <= 1'b0;
      target_q <= '0;
      idx_q    <= '0;
    end else begin
      taken_q  <= taken_d;
      target_q <= target_d;
      idx_q    <= idx_d;
    end
  end

  assign taken_o  = taken_q;
  assign target_o = target_q;
  assign idx_o    = idx_q;

endmodule

// File: rtl/branch_predictor_btb.sv
// Branch target buffer with 2-bit direction counters: predicts at Fetch,
// checks at Execute, raises a redirect on mispredict and trains the table.
// Latency: Fetch lookup and Execute mispredict are combinational; training
//          and the D/E prediction registers update at the clock edge.
// Backpressure: StallD/StallE hold their stage (StallE also blocks training);
//          FlushD/FlushE clear their stage and take priority over stall.
//
// Ports: clk, reset (sync, active-low); PCF -> PredTakenF/PredTargetF;
//        StallD/FlushD/StallE/FlushE pipeline control; BranchE/JumpE/TakenE/
//        PCE/TargetE resolution -> MispredictE/RedirectPCE.
// Build option: define BP_GSHARE_EN to index the direction counters with
//        PC XOR global history; otherwise counters live alongside each entry.
module branch_predictor_btb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned GHR_BITS = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            TakenE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] TargetE,
  output logic            MispredictE,
  output logic [XLEN-1:0] RedirectPCE
);
  import bp_pkg::*;

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  // The carried index holds the direction index above the PC index when
  // gshare is on, because the history used at Fetch is gone by Execute.
`ifdef BP_GSHARE_EN
  localparam int unsigned IW = 2 * IDX;
`else
  localparam int unsigned IW = IDX;
`endif

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } btb_entry_t;

  btb_entry_t btb_q [ENTRIES];
  btb_entry_t btb_d [ENTRIES];
  ctr_t       ctr_q [ENTRIES];
  ctr_t       ctr_d [ENTRIES];

  // ---------------- Fetch lookup ----------------
  logic [IDX-1:0]   pc_idx_f, dir_idx_f;
  logic [TAG_W-1:0] tag_f;
  logic [IW-1:0]    idx_f;
  logic             hit_f;

  assign pc_idx_f = PCF[IDX+1:2];
  assign tag_f    = PCF[XLEN-1:IDX+2];

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  assign dir_idx_f = pc_idx_f ^ IDX'(ghr_q);
  assign idx_f     = {dir_idx_f, pc_idx_f};
`else
  assign dir_idx_f = pc_idx_f;
  assign idx_f     = pc_idx_f;
  // Referenced so the parameter stays part of the interface in this build.
  if (GHR_BITS > IDX) begin : g_ghr_bits_unused
  end
`endif

  assign hit_f       = btb_q[pc_idx_f].valid && (btb_q[pc_idx_f].tag == tag_f);
  assign PredTakenF  = hit_f && ctr_taken(ctr_q[dir_idx_f]);
  assign PredTargetF = hit_f ? btb_q[pc_idx_f].target : (PCF + XLEN'(4));

  // ---------------- D and E prediction registers ----------------
  logic            pred_taken_d, pred_taken_e;
  logic [XLEN-1:0] pred_target_d, pred_target_e;
  logic [IW-1:0]   idx_d, idx_e;

  bp_pipe_reg #(.XLEN(XLEN), .IW(IW)) u_pipe_d (
    .clk      (clk),
    .reset    (reset),
    .stall    (StallD),
    .flush    (FlushD),
    .taken_i  (PredTakenF),
    .target_i (PredTargetF),
    .idx_i    (idx_f),
    .taken_o  (pred_taken_d),
    .target_o (pred_target_d),
    .idx_o    (idx_d)
  );

  bp_pipe_reg #(.XLEN(XLEN), .IW(IW)) u_pipe_e (
    .clk      (clk),
    .reset    (reset),
    .stall    (StallE),
    .flush    (FlushE),
    .taken_i  (pred_taken_d),
    .target_i (pred_target_d),
    .idx_i    (idx_d),
    .taken_o  (pred_taken_e),
    .target_o (pred_target_e),
    .idx_o    (idx_e)
  );

  // ---------------- Execute check ----------------
  logic [IDX-1:0]   pc_idx_e, dir_idx_e;
  logic [TAG_W-1:0] tag_e;
  logic             hit_e;
  logic             cf_e;
  logic             mispredict;

`ifdef BP_GSHARE_EN
  assign pc_idx_e  = idx_e[IDX-1:0];
  assign dir_idx_e = idx_e[IW-1:IDX];
`else
  assign pc_idx_e  = idx_e;
  assign dir_idx_e = idx_e;
`endif

  assign tag_e = PCE[XLEN-1:IDX+2];
  // Hit is re-evaluated against the current table at the carried index;
  // the tag still comes from PCE since only the index is carried.
  assign hit_e = btb_q[pc_idx_e].valid && (btb_q[pc_idx_e].tag == tag_e);
  assign cf_e  = BranchE | JumpE;

  always_comb begin
    mispredict = 1'b0;
    if (cf_e) begin
      if (TakenE != pred_taken_e) begin
        mispredict = 1'b1;
      end else if (TakenE && pred_taken_e && (TargetE != pred_target_e)) begin
        mispredict = 1'b1;
      end
    end else if (pred_taken_e) begin
      // Predicted taken on something that is not control flow: the entry
      // belongs to an aliasing PC or stale code.
      mispredict = 1'b1;
    end
  end

  assign MispredictE = mispredict;
  assign RedirectPCE = (mispredict && TakenE) ? TargetE : (PCE + XLEN'(4));

  // ---------------- Training ----------------
  always_comb begin
    btb_d = btb_q;
    ctr_d = ctr_q;
`ifdef BP_GSHARE_EN
    ghr_d = ghr_q;
`endif
    if (!StallE) begin
      if (JumpE) begin
        btb_d[pc_idx_e] = '{valid: 1'b1, tag: tag_e, target: TargetE};
        ctr_d[dir_idx_e] = ST;
      end else if (BranchE) begin
        if (hit_e) begin
          ctr_d[dir_idx_e] = sat_update(ctr_q[dir_idx_e], TakenE);
          if (TakenE) begin
            btb_d[pc_idx_e].target = TargetE;
          end
        end else if (TakenE) begin
          btb_d[pc_idx_e] = '{valid: 1'b1, tag: tag_e, target: TargetE};
          ctr_d[dir_idx_e] = WT;
        end
`ifdef BP_GSHARE_EN
        ghr_d = GHR_BITS'({ghr_q, TakenE});
`endif
      end else if (pred_taken_e) begin
        btb_d[pc_idx_e].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '0;
        ctr_q[i] <= CTR_RST;
      end
`ifdef BP_GSHARE_EN
      ghr_q <= '0;
`endif
    end else begin
      btb_q <= btb_d;
      ctr_q <= ctr_d;
`ifdef BP_GSHARE_EN
      ghr_q <= ghr_d;
`endif
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;
  localparam int NENT = 64;
  localparam logic [31:0] FILL = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF, PredTargetF, PCE, TargetE, RedirectPCE;
  logic        PredTakenF, StallD, FlushD, StallE, FlushE;
  logic        BranchE, JumpE, TakenE, MispredictE;

  always #5 clk = ~clk;

  branch_predictor_btb #(.XLEN(32), .ENTRIES(NENT), .GHR_BITS(6)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF), .StallD(StallD), .FlushD(FlushD),
    .StallE(StallE), .FlushE(FlushE), .BranchE(BranchE), .JumpE(JumpE),
    .TakenE(TakenE), .PCE(PCE), .TargetE(TargetE),
    .MispredictE(MispredictE), .RedirectPCE(RedirectPCE)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  bit          m_val [NENT];
  logic [31:0] m_tag [NENT];
  logic [31:0] m_tgt [NENT];
  int          m_ctr [NENT];
  bit          md_t, me_t;
  logic [31:0] md_tgt, me_tgt;
  int          md_i, me_i;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (NENT * 4);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return m_val[i] && (m_tag[i] == tag_of(pc));
  endfunction

  function automatic bit m_ptaken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mis();
    if (BranchE || JumpE)
      return (TakenE != me_t) || (TakenE && me_t && (TargetE != me_tgt));
    return me_t;
  endfunction

  function automatic logic [31:0] m_redir();
    return (m_mis() && TakenE) ? TargetE : PCE + 32'd4;
  endfunction

  task automatic m_edge();
    bit ft;
    logic [31:0] ftg;
    int fi, ei;
    bit h;
    ft = m_ptaken(PCF);
    ftg = m_ptarget(PCF);
    fi = idx_of(PCF);
    if (!reset) begin
      for (int i = 0; i < NENT; i++) begin
        m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      md_t = 0; md_tgt = 0; md_i = 0;
      me_t = 0; me_tgt = 0; me_i = 0;
      return;
    end
    if (!StallE) begin
      ei = me_i;
      if (JumpE) begin
        m_val[ei] = 1; m_tag[ei] = tag_of(PCE); m_tgt[ei] = TargetE; m_ctr[ei] = 3;
      end else if (BranchE) begin
        h = m_val[ei] && (m_tag[ei] == tag_of(PCE));
        if (h) begin
          if (TakenE) begin
            m_ctr[ei] = (m_ctr[ei] == 3) ? 3 : m_ctr[ei] + 1;
            m_tgt[ei] = TargetE;
          end else begin
            m_ctr[ei] = (m_ctr[ei] == 0) ? 0 : m_ctr[ei] - 1;
          end
        end else if (TakenE) begin
          m_val[ei] = 1; m_tag[ei] = tag_of(PCE); m_tgt[ei] = TargetE; m_ctr[ei] = 2;
        end
      end else if (me_t) begin
        m_val[ei] = 0;
      end
    end
    if (FlushE) begin
      me_t = 0; me_tgt = 0; me_i = 0;
    end else if (!StallE) begin
      me_t = md_t; me_tgt = md_tgt; me_i = md_i;
    end
    if (FlushD) begin
      md_t = 0; md_tgt = 0; md_i = 0;
    end else if (!StallD) begin
      md_t = ft; md_tgt = ftg; md_i = fi;
    end
  endtask

  // ---------------- cycle driver + compare ----------------
  logic        s_ptf, s_mis;
  logic [31:0] s_ptg, s_red;
  logic        a_ptf, c_mis;
  logic [31:0] a_ptg, c_red;

  task automatic cyc();
    @(negedge clk);
    s_ptf = PredTakenF; s_ptg = PredTargetF; s_mis = MispredictE; s_red = RedirectPCE;
    if (chk_en) begin
      check("cyc_PredTakenF", PredTakenF, m_ptaken(PCF));
      check("cyc_PredTargetF", PredTargetF, m_ptarget(PCF));
      check("cyc_MispredictE", MispredictE, m_mis());
      check("cyc_RedirectPCE", RedirectPCE, m_redir());
    end
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic e_idle();
    BranchE = 0; JumpE = 0; TakenE = 0; PCE = FILL; TargetE = 0;
  endtask

  // Fetch pc, two cycles later resolve it in Execute.
  task automatic run_br(input logic [31:0] pc, input logic br, input logic jmp,
                        input logic tk, input logic [31:0] tgt);
    PCF = pc; e_idle(); cyc();
    a_ptf = s_ptf; a_ptg = s_ptg;
    PCF = FILL; cyc();
    PCE = pc; BranchE = br; JumpE = jmp; TakenE = tk; TargetE = tgt; cyc();
    c_mis = s_mis; c_red = s_red;
    e_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 0; PCF = 32'h100; StallD = 0; FlushD = 0; StallE = 0; FlushE = 0;
    e_idle();
    cyc();
    chk_en = 1;
    cyc();
    reset = 1;
    cyc();
    check("reset_ptf", s_ptf, 0);
    check("reset_ptg", s_ptg, 32'h104);
    check("reset_mis", s_mis, 0);

    // PC+4 wraps
    run_br(32'hFFFF_FFFC, 0, 0, 0, 0);
    check("wrap_ptg", a_ptg, 32'h0);
    check("wrap_red", c_red, 32'h0);

    // not-taken branch: no mispredict, no allocation
    run_br(32'h100, 1, 0, 0, 32'h80);
    check("nt_ptf", a_ptf, 0);
    check("nt_ptg", a_ptg, 32'h104);
    check("nt_mis", c_mis, 0);
    // first taken: mispredict, allocate ctr=2
    run_br(32'h100, 1, 0, 1, 32'h80);
    check("alloc_ptf", a_ptf, 0);
    check("alloc_mis", c_mis, 1);
    check("alloc_red", c_red, 32'h80);
    run_br(32'h100, 1, 0, 1, 32'h80);
    check("hit_ptf", a_ptf, 1);
    check("hit_ptg", a_ptg, 32'h80);
    check("hit_mis", c_mis, 0);
    run_br(32'h100, 1, 0, 1, 32'h80);
    run_br(32'h100, 1, 0, 1, 32'h80);
    run_br(32'h100, 1, 0, 0, 32'h80);
    check("nt1_mis", c_mis, 1);
    check("nt1_red", c_red, 32'h104);
    run_br(32'h100, 1, 0, 0, 32'h80);
    check("sat_hi_ptf", a_ptf, 1);
    run_br(32'h100, 1, 0, 0, 32'h80);
    check("ctr1_ptf", a_ptf, 0);
    run_br(32'h100, 1, 0, 0, 32'h80);
    run_br(32'h100, 1, 0, 1, 32'h80);
    run_br(32'h100, 1, 0, 1, 32'h80);
    check("sat_lo_ptf", a_ptf, 0);
    run_br(32'h100, 1, 0, 1, 32'h80);
    check("relearn_ptf", a_ptf, 1);

    // jal, then target change
    run_br(32'h200, 0, 1, 1, 32'h400);
    check("jal_ptf", a_ptf, 0);
    check("jal_red", c_red, 32'h400);
    run_br(32'h200, 0, 1, 1, 32'h500);
    check("jal2_ptg", a_ptg, 32'h400);
    check("jal2_mis", c_mis, 1);
    check("jal2_red", c_red, 32'h500);
    run_br(32'h200, 0, 1, 1, 32'h500);
    check("jal3_ptg", a_ptg, 32'h500);
    check("jal3_mis", c_mis, 0);

    // stall trains once: bring 0x104 to ctr=1 first
    run_br(32'h104, 1, 0, 1, 32'h40);
    run_br(32'h104, 1, 0, 0, 32'h40);
    PCF = 32'h104; e_idle(); cyc();
    check("stall_pre_ptf", s_ptf, 0);
    PCF = FILL; cyc();
    PCE = 32'h104; BranchE = 1; TakenE = 1; TargetE = 32'h40;
    StallE = 1; StallD = 1;
    for (int k = 0; k < 3; k++) cyc();
    StallE = 0; StallD = 0; cyc();
    e_idle();
    run_br(32'h104, 1, 0, 0, 32'h40);
    check("stall_once_ptf", a_ptf, 1);
    run_br(32'h104, 1, 0, 0, 32'h40);
    check("stall_not_multi_ptf", a_ptf, 0);

    // FlushD then FlushE discard a predicted-taken entry
    PCF = 32'h200; FlushD = 1; cyc();
    FlushD = 0; PCF = FILL; cyc();
    PCE = 32'h200; cyc();
    check("flushd_mis", s_mis, 0);
    e_idle();
    PCF = 32'h200; cyc();
    PCF = FILL; FlushE = 1; cyc();
    FlushE = 0; PCE = 32'h200; cyc();
    check("flushe_mis", s_mis, 0);
    e_idle();
    run_br(32'h200, 0, 1, 1, 32'h500);
    check("flushe_kept_ptf", a_ptf, 1);
    check("flushe_kept_ptg", a_ptg, 32'h500);

    // aliasing at index 0 and stale hit
    run_br(32'h100, 1, 0, 1, 32'h80);
    check("alias_ptf", a_ptf, 0);
    run_br(32'h200, 0, 0, 0, 32'h0);
    check("alias_tagmiss_ptf", a_ptf, 0);
    check("alias_tagmiss_mis", c_mis, 0);
    run_br(32'h100, 0, 0, 0, 32'h0);
    check("stale_ptf", a_ptf, 1);
    check("stale_mis", c_mis, 1);
    check("stale_red", c_red, 32'h104);
    PCF = 32'h100; cyc();
    check("stale_cleared_ptf", s_ptf, 0);
    check("stale_cleared_ptg", s_ptg, 32'h104);

    // reset mid-stream drops the in-flight prediction and the table
    run_br(32'h100, 1, 0, 1, 32'h80);
    PCF = 32'h100; cyc();
    check("midrst_pre_ptf", s_ptf, 1);
    PCF = FILL; reset = 0; cyc();
    reset = 1; PCF = 32'h100; PCE = 32'h100; cyc();
    check("midrst_mis", s_mis, 0);
    check("midrst_ptf", s_ptf, 0);
    e_idle();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
